// File: rtl/ctrl_unit_if.sv
// rtl/ctrl_unit_if.sv - control/status and program-memory bus between ctrl_unit and the accumulator datapath
// Optional input-wait handshake present only when CTRL_IN_WAIT_EN is defined.
interface ctrl_unit_if #(
  parameter int ADDR_W = 8
);
  logic              run_cu;
  logic [7:0]        mem_cu;
  logic              zero_cu;
  logic              pos_cu;
  logic [ADDR_W-1:0] pc_cu;
  logic [1:0]        muxsel_cu;
  logic [7:0]        imm_cu;
  logic              accwr_cu;
  logic [2:0]        rfaddr_cu;
  logic              rfwr_cu;
  logic [2:0]        alusel_cu;
  logic [1:0]        shiftsel_cu;
  logic              outen_cu;
  logic              halt_cu;
`ifdef CTRL_IN_WAIT_EN
  logic              in_vld_cu;
  logic              in_ack_cu;

  modport master (
    input  run_cu, mem_cu, zero_cu, pos_cu, in_vld_cu,
    output pc_cu, muxsel_cu, imm_cu, accwr_cu, rfaddr_cu, rfwr_cu,
           alusel_cu, shiftsel_cu, outen_cu, halt_cu, in_ack_cu
  );

  modport slave (
    output run_cu, mem_cu, zero_cu, pos_cu, in_vld_cu,
    input  pc_cu, muxsel_cu, imm_cu, accwr_cu, rfaddr_cu, rfwr_cu,
           alusel_cu, shiftsel_cu, outen_cu, halt_cu, in_ack_cu
  );
`else
  modport master (
    input  run_cu, mem_cu, zero_cu, pos_cu,
    output pc_cu, muxsel_cu, imm_cu, accwr_cu, rfaddr_cu, rfwr_cu,
           alusel_cu, shiftsel_cu, outen_cu, halt_cu
  );

  modport slave (
    output run_cu, mem_cu, zero_cu, pos_cu,
    input  pc_cu, muxsel_cu, imm_cu, accwr_cu, rfaddr_cu, rfwr_cu,
           alusel_cu, shiftsel_cu, outen_cu, halt_cu
  );
`endif
endinterface

// File: rtl/ctrl_unit.sv
// rtl/ctrl_unit.sv - multi-cycle fetch/operand/execute control unit for the 8-bit accumulator datapath
// Define CTRL_IN_WAIT_EN to make IN wait for in_vld_cu and acknowledge with in_ack_cu.
module ctrl_unit #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic        clk_cu,
  input  logic        rst_cu,
  ctrl_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_OPERAND = 2'd1,
    S_EXEC    = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JP  = 4'h6;
  localparam logic [3:0] OP_ADD = 4'h7;
  localparam logic [3:0] OP_SUB = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_OR  = 4'hA;
  localparam logic [3:0] OP_NOT = 4'hB;
  localparam logic [3:0] OP_IDC = 4'hC;
  localparam logic [3:0] OP_SHF = 4'hD;
  localparam logic [3:0] OP_IN  = 4'hE;
  localparam logic [3:0] OP_SYS = 4'hF;

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        opr_q, opr_d;

  logic [3:0]        opcode;
  logic [3:0]        fetch_op;
  logic [ADDR_W-1:0] jmp_tgt;
  logic              in_ready;
  logic              unused_ir3;

  logic [1:0]        muxsel;
  logic              accwr;
  logic              rfwr;
  logic [2:0]        alusel;
  logic [1:0]        shiftsel;
  logic              outen;
  logic              halt;
  logic              in_ack;

  assign opcode     = ir_q[7:4];
  assign fetch_op   = bus.mem_cu[7:4];
  assign jmp_tgt    = opr_q[ADDR_W-1:0];
  assign unused_ir3 = ir_q[3];

`ifdef CTRL_IN_WAIT_EN
  assign in_ready = bus.in_vld_cu;
`else
  assign in_ready = 1'b1;
`endif

  always_ff @(posedge clk_cu or negedge rst_cu) begin
    if (!rst_cu) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RST;
      ir_q    <= 8'h00;
      opr_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.run_cu) begin
          ir_d = bus.mem_cu;
          pc_d = pc_q + PC_ONE;
          if (fetch_op == OP_LDI || fetch_op == OP_JMP ||
              fetch_op == OP_JZ  || fetch_op == OP_JP)
            state_d = S_OPERAND;
          else
            state_d = S_EXEC;
        end
      end
      S_OPERAND: begin
        opr_d   = bus.mem_cu;
        pc_d    = pc_q + PC_ONE;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_JMP: pc_d = jmp_tgt;
          OP_JZ:  if (bus.zero_cu) pc_d = jmp_tgt;
          OP_JP:  if (bus.pos_cu)  pc_d = jmp_tgt;
          OP_IN:  if (!in_ready)   state_d = S_EXEC;
          OP_SYS: if (ir_q[0])     state_d = S_HALT;
          default: ;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Controls are decoded only in EXEC so a reset clears them combinationally via state_q.
  always_comb begin
    muxsel   = 2'b00;
    accwr    = 1'b0;
    rfwr     = 1'b0;
    alusel   = 3'b000;
    shiftsel = 2'b00;
    outen    = 1'b0;
    in_ack   = 1'b0;
    halt     = (state_q == S_HALT);
    if (state_q == S_EXEC) begin
      case (opcode)
        OP_LDA: begin muxsel = 2'b01; accwr = 1'b1; end
        OP_STA: rfwr = 1'b1;
        OP_LDI: begin muxsel = 2'b11; accwr = 1'b1; end
        OP_ADD: begin alusel = 3'b001; accwr = 1'b1; end
        OP_SUB: begin alusel = 3'b010; accwr = 1'b1; end
        OP_AND: begin alusel = 3'b011; accwr = 1'b1; end
        OP_OR:  begin alusel = 3'b100; accwr = 1'b1; end
        OP_NOT: begin alusel = 3'b101; accwr = 1'b1; end
        OP_IDC: begin alusel = ir_q[0] ? 3'b111 : 3'b110; accwr = 1'b1; end
        OP_SHF: begin shiftsel = ir_q[1:0]; accwr = 1'b1; end
        OP_IN: begin
          muxsel = 2'b10;
          accwr  = in_ready;
          in_ack = in_ready;
        end
        OP_SYS: outen = ~ir_q[0];
        default: ;
      endcase
    end
  end

  assign bus.pc_cu       = pc_q;
  assign bus.imm_cu      = opr_q;
  assign bus.rfaddr_cu   = ir_q[2:0];
  assign bus.muxsel_cu   = muxsel;
  assign bus.accwr_cu    = accwr;
  assign bus.rfwr_cu     = rfwr;
  assign bus.alusel_cu   = alusel;
  assign bus.shiftsel_cu = shiftsel;
  assign bus.outen_cu    = outen;
  assign bus.halt_cu     = halt;
`ifdef CTRL_IN_WAIT_EN
  assign bus.in_ack_cu   = in_ack;
`else
  logic unused_in_ack;
  assign unused_in_ack = in_ack;
`endif

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Multi-cycle control unit that drives the 8-bit accumulator datapath, which is the other end of the datapath's control/status interface. It fetches instruction bytes from an external combinational program memory and decodes them. It sequences each instruction through a small FSM, asserts the datapath control strobes for exactly one execute cycle, and consumes the datapath's zero/positive flags for conditional jumps.

## Interface
- ADDR_W, 8, program counter width (1..8); jump targets use operand[ADDR_W-1:0]
- RESET_PC, 0, program counter value loaded on reset

- clk_cu  in  1  clock, rising edge
- rst_cu  in  1  asynchronous, active-low reset
- run_cu  in  1  FETCH advances only while 1; other states ignore it
- mem_cu  in  8  program byte at address pc_cu, valid same cycle
- zero_cu  in  1  from datapath zero flag
- pos_cu  in  1  from datapath positive flag
- pc_cu  out  ADDR_W  program counter
- muxsel_cu  out  2  datapath mux select
- imm_cu  out  8  operand register, to datapath immediate input
- accwr_cu  out  1  accumulator write strobe
- rfaddr_cu  out  3  register address, always IR[2:0]
- rfwr_cu  out  1  register file write strobe
- alusel_cu  out  3  ALU op select
- shiftsel_cu  out  2  shifter select
- outen_cu  out  1  output enable strobe
- halt_cu  out  1  high in HALT
- in_vld_cu  in  1  input data valid (CTRL_IN_WAIT_EN only)
- in_ack_cu  out  1  input consumed (CTRL_IN_WAIT_EN only)

## Operation
- Registers: pc, IR (8 b), OPR (8 b), state. Reset values: pc=RESET_PC, IR=0, OPR=0, state=FETCH.
- All strobes and selects are 0 outside EXEC. This also holds during reset. halt_cu=0 at reset.
- FETCH: if run_cu, IR<=mem_cu and pc<=pc+1. Go to OPERAND for LDI/JMP/JZ/JP, otherwise to EXEC.
- OPERAND: OPR<=mem_cu, pc<=pc+1, go to EXEC.
- EXEC: drive controls from IR for one cycle, then go to FETCH. HALT goes to HALT instead.
- HALT: absorbing. Only reset exits it.
- Opcode IR[7:4]; datapath controls shown as mux/alu/shift:
  - 0 NOP
  - 1 LDA: muxsel 01, accwr
  - 2 STA: rfwr
  - 3 LDI: muxsel 11, accwr
  - 4 JMP
  - 5 JZ
  - 6 JP
  - 7 ADD: 00/001/00, accwr
  - 8 SUB: 00/010/00, accwr
  - 9 AND: 00/011/00, accwr
  - A OR: 00/100/00, accwr
  - B NOT: 00/101/00, accwr
  - C: INC (IR[0]=0, alu 110) or DEC (IR[0]=1, alu 111); mux 00, shift 00, accwr
  - D SHIFT: 00/000/IR[1:0], accwr
  - E IN: muxsel 10, accwr
  - F: OUT (IR[0]=0, outen) or HALT (IR[0]=1)
- JZ/JP in EXEC: drive muxsel 00, alusel 000, shiftsel 00 so the flags reflect the accumulator. Load pc<=OPR if zero_cu (JZ) or pos_cu (JP); otherwise pc is unchanged. JMP loads unconditionally.
- pc increments wrap modulo 2^ADDR_W.
- Reserved IR[3:0] bits are ignored.

## Timing
- Single-byte instruction: 2 cycles (FETCH, EXEC). Two-byte instruction: 3 cycles.
- Strobes are valid for exactly one EXEC cycle. Datapath writes occur on the rising edge ending EXEC.
- Jump target appears on pc_cu the cycle after EXEC.
- run_cu low stalls in FETCH with pc held. Deasserting run_cu mid-instruction does not stall OPERAND or EXEC.
- Reset asserted in any state: immediately forces reset values and clears strobes combinationally. Execution resumes with FETCH at RESET_PC on the first edge after release.

## Configuration
- CTRL_IN_WAIT_EN defined:
  - in_vld_cu/in_ack_cu exist.
  - IN stays in EXEC until in_vld_cu=1. accwr_cu is low while waiting. muxsel is 10 throughout.
  - The cycle in which in_vld_cu=1 asserts accwr_cu and in_ack_cu together, then goes to FETCH.
  - in_ack_cu resets to 0.
- Undefined: ports absent; IN completes in one EXEC cycle unconditionally.

## Test plan
- Reset mid-EXEC of ADD (rst_cu low) -> pc_cu=RESET_PC, every strobe 0, halt_cu=0 within the same cycle; first FETCH at RESET_PC after release.
- Program 0x30 0x05, 0x23 -> cycle 3: muxsel 11, imm 0x05, accwr 1; cycle 5: rfwr 1, rfaddr 3; pc 0→2→3.
- ADD R3 (0x73) -> EXEC: muxsel 00, alusel 001, shiftsel 00, accwr 1, rfaddr 3, 2-cycle latency.
- JZ 0x10 (0x50 0x10) with zero_cu=1 -> next pc 0x10; repeat with zero_cu=0 -> pc continues at 2; JP with pos_cu=0 -> not taken.
- NOP at 0xFF, ADDR_W=8 -> pc_cu wraps to 0x00; run_cu=0 for 4 cycles in FETCH -> pc frozen, strobes 0.
- HALT (0xF1) -> halt_cu=1 and pc frozen for ≥10 cycles regardless of run_cu. With CTRL_IN_WAIT_EN, IN (0xE0) with in_vld_cu low 3 cycles -> accwr 0, then accwr and in_ack_cu both high for one cycle when in_vld_cu=1.
